piso_ctrl: RTL

- Sequencer for the PE-array parallel-in/serial-out unloader (PE_NUM lanes of SRL chains, always-enabled shift).
- Accepts batches of SRL_DEPTH parallel result vectors from the PE array over a valid/ready handshake.
- Drives the unloader's load strobe and emits a cycle-accurate serial valid and last marker.
- Schedules back-to-back batches with no bubbles, and gates new batches on downstream credit.

---
 rtl/piso_ctrl_pkg.sv | 33 +++
 rtl/piso_ctrl_vld_delay.sv | 44 ++++
 rtl/piso_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/piso_ctrl_pkg.sv
// Shared constants for the PE-array PISO unloader sequencer: default array
// geometry, FSM state encoding and the per-beat status carried down the
// valid delay line.
package piso_ctrl_pkg;

   // Default array geometry (lanes, SRL depth, datapath width).
   localparam int DEF_PE_NUM  = 8;
   localparam int DEF_REG_NUM = 4;
   localparam int DATA_WIDTH  = 16;

   // FSM state encoding, kept as plain constants so legacy tools and
   // waveform scripts that decode the raw 2-bit value keep working.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Status that travels alongside the serial data through the SRL latency.
   typedef struct packed {
      logic active;
      logic last_beat;
   } vld_t;

   // Number of clock cycles one batch occupies the serial output.
   function automatic int batch_len(input int pe_num, input int depth);
      return pe_num * depth;
   endfunction

   // Counter width able to hold 0..beats-1 (at least one bit).
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/piso_ctrl_vld_delay.sv
// Fixed-latency delay line for the {active, last_beat} status pair. Its
// depth equals the SRL depth so the status lines up with the serial words
// leaving the unloader. No enable: the SRLs shift every cycle.
module vld_delay
   import piso_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_REG_NUM
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       any_set
);

   logic [1:0]       stage_reg [DEPTH];
   logic [DEPTH-1:0] occ;

   // Shift the status pair one stage per cycle; clear drops everything in flight.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   // Collect the active bit of every stage so busy covers words in flight.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_occ
         assign occ[gi] = stage_reg[gi][1];
      end
   endgenerate

   assign dout    = stage_reg[DEPTH-1];
   assign any_set = |occ;

endmodule

// File: rtl/piso_ctrl.sv
// Sequencer for the PE-array parallel-in/serial-out unloader. Accepts
// batches of SRL_DEPTH parallel vectors, drives the unloader load strobe,
// and produces serial valid/last markers aligned to the SRL output.
module piso_ctrl
   import piso_ctrl_pkg::*;
#(
   parameter int PE_NUM    = DEF_PE_NUM,
   parameter int SRL_DEPTH = DEF_REG_NUM
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  logic out_ready,
   output logic load,
   output logic out_valid,
   output logic out_last,
   output logic busy,
   output logic err
);

   // Beat counter geometry is derived from the array size, never overridden.
   localparam int PERIOD = batch_len(PE_NUM, SRL_DEPTH);
   localparam int CNT_W  = cnt_width(PERIOD);

   localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(SRL_DEPTH - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PERIOD - 1);

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;

   logic fire_idle;
   logic load_i;
   logic active;
   logic last_beat;
   vld_t tap_in;
   vld_t tap_out;
   logic tap_any;

   // Strobe and activity decode. The idle-to-load cycle is combinational so
   // the first vector is taken with no bubble and counts as beat 0. Nothing
   // is loaded or marked active while reset is held.
   always_comb begin
      fire_idle = rst_n && (state_reg == ST_IDLE) && in_valid && out_ready;
      load_i    = fire_idle || (rst_n && (state_reg == ST_LOAD));
      active    = fire_idle ||
                  (rst_n && ((state_reg == ST_LOAD) || (state_reg == ST_DRAIN)));
      last_beat = active && (cnt_reg == LAST_BEAT);
   end

   // Next-state and counter. Each active cycle advances the beat count; the
   // final beat either chains straight into the next batch (credit and data
   // present) or returns to idle. An illegal encoding falls back to idle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (active) begin
         if (cnt_reg == LAST_BEAT) begin
            cnt_next   = '0;
            state_next = (in_valid && out_ready) ? ST_LOAD : ST_IDLE;
         end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
            state_next = (cnt_reg >= LAST_LOAD) ? ST_DRAIN : ST_LOAD;
         end
      end else if ((state_reg != ST_IDLE) && (state_reg != ST_LOAD) &&
                   (state_reg != ST_DRAIN)) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end
   end

   // Underrun: a strobe with no vector behind it. The SRLs cannot stall, so
   // the batch runs on and the fault is latched until reset.
   always_comb begin
      err_next = err_reg || (load_i && !in_valid);
   end

   // State, count and sticky error registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   assign tap_in.active    = active;
   assign tap_in.last_beat = last_beat;

   // Status rides a delay line as deep as the SRLs so it meets the words.
   vld_delay #(
      .DEPTH (SRL_DEPTH)
   ) u_vld_delay (
      .clk     (clk),
      .clr_n   (rst_n),
      .din     (tap_in),
      .dout    (tap_out),
      .any_set (tap_any)
   );

   assign load      = load_i;
   assign in_ready  = load_i;
   assign out_valid = tap_out.active;
   assign out_last  = tap_out.last_beat;
   assign busy      = active || tap_any;
   assign err       = err_reg;

endmodule
